// File: rtl/eth_hdr_serializer.sv
// Ethernet header serializer: emits the 14 header bytes (dest MAC, src MAC,
// EtherType, most significant byte first) followed by the payload stream as
// one byte-wide AXI-Stream frame. The output is registered and backed by a
// one-entry skid register, so no beat is lost or duplicated when the
// downstream ready signal stalls.
module eth_hdr_serializer #(
    parameter int USER_WIDTH = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  s_eth_hdr_valid,
    output logic                  s_eth_hdr_ready,
    input  logic [47:0]           s_eth_dest_mac,
    input  logic [47:0]           s_eth_src_mac,
    input  logic [15:0]           s_eth_type,
    input  logic [7:0]            s_eth_payload_axis_tdata,
    input  logic                  s_eth_payload_axis_tvalid,
    output logic                  s_eth_payload_axis_tready,
    input  logic                  s_eth_payload_axis_tlast,
    input  logic [USER_WIDTH-1:0] s_eth_payload_axis_tuser,
    output logic [7:0]            m_axis_tdata,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic                  m_axis_tlast,
    output logic [USER_WIDTH-1:0] m_axis_tuser,
    output logic                  busy
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_HDR     = 2'd1,
        ST_PAYLOAD = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [3:0]            hdr_cnt_q, hdr_cnt_d;
    logic [47:0]           dest_q, dest_d;
    logic [47:0]           src_q, src_d;
    logic [15:0]           type_q, type_d;

    // Beat offered to the output stage this cycle
    logic                  int_valid_s;
    logic [7:0]            int_tdata_s;
    logic                  int_tlast_s;
    logic [USER_WIDTH-1:0] int_tuser_s;
    logic                  int_ready_q, int_ready_d;

    // Output register and skid register
    logic [7:0]            out_tdata_q, out_tdata_d;
    logic                  out_valid_q, out_valid_d;
    logic                  out_tlast_q, out_tlast_d;
    logic [USER_WIDTH-1:0] out_tuser_q, out_tuser_d;
    logic [7:0]            tmp_tdata_q, tmp_tdata_d;
    logic                  tmp_valid_q, tmp_valid_d;
    logic                  tmp_tlast_q, tmp_tlast_d;
    logic [USER_WIDTH-1:0] tmp_tuser_q, tmp_tuser_d;

    logic                  pay_fire_s;

    // Selects header byte idx (0 = dest[47:40] ... 13 = type[7:0]).
    function automatic logic [7:0] hdr_byte(input logic [3:0] idx, input logic [111:0] hdr);
        logic [111:0] sh;
        sh = hdr << {idx, 3'b000};
        if (idx <= 4'd13) begin
            return sh[111:104];
        end else begin
            return 8'h00;
        end
    endfunction

    assign s_eth_hdr_ready           = (state_q == ST_IDLE);
    assign s_eth_payload_axis_tready = (state_q == ST_PAYLOAD) && int_ready_q;
    assign pay_fire_s                = s_eth_payload_axis_tready && s_eth_payload_axis_tvalid;
    assign busy                      = (state_q != ST_IDLE);

    assign m_axis_tdata  = out_tdata_q;
    assign m_axis_tvalid = out_valid_q;
    assign m_axis_tlast  = out_tlast_q;
    assign m_axis_tuser  = out_tuser_q;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: header handshake, 14 header pushes, payload until tlast
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (s_eth_hdr_valid) state_d = ST_HDR;
                else                 state_d = ST_IDLE;
            end
            ST_HDR: begin
                if (int_ready_q && (hdr_cnt_q == 4'd13)) state_d = ST_PAYLOAD;
                else                                     state_d = ST_HDR;
            end
            ST_PAYLOAD: begin
                if (pay_fire_s && s_eth_payload_axis_tlast) state_d = ST_IDLE;
                else                                        state_d = ST_PAYLOAD;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Output decode: which beat (if any) is pushed into the output stage
    always_comb begin
        int_valid_s = 1'b0;
        int_tdata_s = 8'h00;
        int_tlast_s = 1'b0;
        int_tuser_s = {USER_WIDTH{1'b0}};
        case (state_q)
            ST_HDR: begin
                if (int_ready_q) begin
                    int_valid_s = 1'b1;
                    int_tdata_s = hdr_byte(hdr_cnt_q, {dest_q, src_q, type_q});
                end else begin
                    int_valid_s = 1'b0;
                end
            end
            ST_PAYLOAD: begin
                if (pay_fire_s) begin
                    int_valid_s = 1'b1;
                    int_tdata_s = s_eth_payload_axis_tdata;
                    int_tlast_s = s_eth_payload_axis_tlast;
                    int_tuser_s = s_eth_payload_axis_tuser;
                end else begin
                    int_valid_s = 1'b0;
                end
            end
            default: int_valid_s = 1'b0;
        endcase
    end

    // Header capture and byte counter; the counter wraps to 0 after byte 13
    always_comb begin
        dest_d    = dest_q;
        src_d     = src_q;
        type_d    = type_q;
        hdr_cnt_d = hdr_cnt_q;
        if ((state_q == ST_IDLE) && s_eth_hdr_valid) begin
            dest_d    = s_eth_dest_mac;
            src_d     = s_eth_src_mac;
            type_d    = s_eth_type;
            hdr_cnt_d = 4'd0;
        end else if ((state_q == ST_HDR) && int_ready_q) begin
            hdr_cnt_d = (hdr_cnt_q == 4'd13) ? 4'd0 : hdr_cnt_q + 4'd1;
        end else begin
            hdr_cnt_d = hdr_cnt_q;
        end
    end

    // Output stage: steer the pushed beat to the output or skid register,
    // drain the skid when downstream accepts, and predict next-cycle ready
    always_comb begin
        out_tdata_d = out_tdata_q;
        out_valid_d = out_valid_q;
        out_tlast_d = out_tlast_q;
        out_tuser_d = out_tuser_q;
        tmp_tdata_d = tmp_tdata_q;
        tmp_valid_d = tmp_valid_q;
        tmp_tlast_d = tmp_tlast_q;
        tmp_tuser_d = tmp_tuser_q;
        int_ready_d = m_axis_tready | (~tmp_valid_q & (~out_valid_q | ~int_valid_s));
        if (int_ready_q) begin
            if (m_axis_tready || !out_valid_q) begin
                out_valid_d = int_valid_s;
                out_tdata_d = int_tdata_s;
                out_tlast_d = int_tlast_s;
                out_tuser_d = int_tuser_s;
            end else begin
                tmp_valid_d = int_valid_s;
                tmp_tdata_d = int_tdata_s;
                tmp_tlast_d = int_tlast_s;
                tmp_tuser_d = int_tuser_s;
            end
        end else if (m_axis_tready) begin
            out_valid_d = tmp_valid_q;
            out_tdata_d = tmp_tdata_q;
            out_tlast_d = tmp_tlast_q;
            out_tuser_d = tmp_tuser_q;
            tmp_valid_d = 1'b0;
        end else begin
            out_valid_d = out_valid_q;
        end
    end

    // Datapath registers: header, counter, output and skid stages
    always_ff @(posedge clk) begin
        if (rst) begin
            hdr_cnt_q   <= 4'd0;
            dest_q      <= 48'h0;
            src_q       <= 48'h0;
            type_q      <= 16'h0;
            int_ready_q <= 1'b0;
            out_tdata_q <= 8'h00;
            out_valid_q <= 1'b0;
            out_tlast_q <= 1'b0;
            out_tuser_q <= {USER_WIDTH{1'b0}};
            tmp_tdata_q <= 8'h00;
            tmp_valid_q <= 1'b0;
            tmp_tlast_q <= 1'b0;
            tmp_tuser_q <= {USER_WIDTH{1'b0}};
        end else begin
            hdr_cnt_q   <= hdr_cnt_d;
            dest_q      <= dest_d;
            src_q       <= src_d;
            type_q      <= type_d;
            int_ready_q <= int_ready_d;
            out_tdata_q <= out_tdata_d;
            out_valid_q <= out_valid_d;
            out_tlast_q <= out_tlast_d;
            out_tuser_q <= out_tuser_d;
            tmp_tdata_q <= tmp_tdata_d;
            tmp_valid_q <= tmp_valid_d;
            tmp_tlast_q <= tmp_tlast_d;
            tmp_tuser_q <= tmp_tuser_d;
        end
    end

endmodule

// File: tb/tb_eth_hdr_serializer.sv
// Bench for eth_hdr_serializer: independent header and payload drivers,
// a frame-level reference (header bytes MSB-first then payload) held as a
// queue of expected beats, and one monitor comparing every accepted beat.
`timescale 1ns/1ps
module tb_eth_hdr_serializer;

    localparam int UW       = 1;
    localparam int WAIT_MAX = 400;

    logic          clk = 1'b0;
    logic          rst;
    logic          s_eth_hdr_valid, s_eth_hdr_ready;
    logic [47:0]   s_eth_dest_mac, s_eth_src_mac;
    logic [15:0]   s_eth_type;
    logic [7:0]    p_tdata;
    logic          p_tvalid, p_tready, p_tlast;
    logic [UW-1:0] p_tuser;
    logic [7:0]    m_tdata;
    logic          m_tvalid, m_tready, m_tlast;
    logic [UW-1:0] m_tuser;
    logic          busy;

    eth_hdr_serializer #(.USER_WIDTH(UW)) dut (
        .clk(clk), .rst(rst),
        .s_eth_hdr_valid(s_eth_hdr_valid), .s_eth_hdr_ready(s_eth_hdr_ready),
        .s_eth_dest_mac(s_eth_dest_mac), .s_eth_src_mac(s_eth_src_mac), .s_eth_type(s_eth_type),
        .s_eth_payload_axis_tdata(p_tdata), .s_eth_payload_axis_tvalid(p_tvalid),
        .s_eth_payload_axis_tready(p_tready), .s_eth_payload_axis_tlast(p_tlast),
        .s_eth_payload_axis_tuser(p_tuser),
        .m_axis_tdata(m_tdata), .m_axis_tvalid(m_tvalid), .m_axis_tready(m_tready),
        .m_axis_tlast(m_tlast), .m_axis_tuser(m_tuser), .busy(busy)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    int tr_mode = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference: expected beats {tuser, tlast, tdata}; stimulus queues
    logic [9:0]  exp_q[$];
    logic [9:0]  cap_q[$];
    int          cap_cyc_q[$];
    int          hs_q[$];
    int          pacc_q[$];
    logic [47:0] hq_d[$], hq_s[$];
    logic [15:0] hq_t[$];
    int          hq_dly[$];
    logic [9:0]  pq[$];
    int          pq_dly[$];
    bit          busy_log[8192];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        vectors++;
        if (act !== expv) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, expv, $time);
        end
    endtask

    task automatic add_hdr(input logic [47:0] d, input logic [47:0] s, input logic [15:0] t, input int dly);
        logic [111:0] h;
        h = {d, s, t};
        hq_d.push_back(d); hq_s.push_back(s); hq_t.push_back(t); hq_dly.push_back(dly);
        for (int i = 0; i < 14; i++) exp_q.push_back({2'b00, h[111-8*i -: 8]});
    endtask

    task automatic add_pay(input logic [7:0] data, input logic last, input logic user, input int dly);
        pq.push_back({user, last, data});
        pq_dly.push_back(dly);
        exp_q.push_back({user, last, data});
    endtask

    task automatic clr();
        cap_q.delete(); cap_cyc_q.delete(); hs_q.delete(); pacc_q.delete();
    endtask

    // Monitor: every accepted output beat must be the next expected beat,
    // and a stalled beat must be held unchanged
    logic       prev_stall = 1'b0;
    logic [9:0] prev_beat  = 10'h0;
    always @(negedge clk) begin
        logic [9:0] e;
        if (cyc < 8192) busy_log[cyc] = busy;
        if (prev_stall) begin
            chk("hold_valid", m_tvalid, 32'd1);
            chk("hold_beat", {m_tuser, m_tlast, m_tdata}, prev_beat);
        end
        if (m_tvalid && m_tready) begin
            cap_q.push_back({m_tuser, m_tlast, m_tdata});
            cap_cyc_q.push_back(cyc);
            if (exp_q.size() == 0) begin
                vectors++; miscompares++;
                $display("FAIL unexpected_beat: got %0h expected none", {m_tuser, m_tlast, m_tdata});
            end else begin
                e = exp_q.pop_front();
                chk("beat", {m_tuser, m_tlast, m_tdata}, e);
            end
        end
        prev_stall = !rst && m_tvalid && !m_tready;
        prev_beat  = {m_tuser, m_tlast, m_tdata};
    end

    // Downstream ready pattern: 0 = always, 1 = toggling, 2 = random
    initial begin
        m_tready = 1'b1;
        forever begin
            @(posedge clk); #1;
            case (tr_mode)
                0:       m_tready = 1'b1;
                1:       m_tready = ~m_tready;
                default: m_tready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    task automatic drv_hdr();
        int dly; int n; bit ok;
        while (hq_d.size() > 0) begin
            dly = hq_dly.pop_front();
            repeat (dly) begin @(posedge clk); #1; end
            s_eth_dest_mac  = hq_d.pop_front();
            s_eth_src_mac   = hq_s.pop_front();
            s_eth_type      = hq_t.pop_front();
            s_eth_hdr_valid = 1'b1;
            ok = 1'b0; n = 0;
            while (!ok && n < WAIT_MAX) begin
                @(negedge clk);
                ok = s_eth_hdr_ready;
                if (ok) hs_q.push_back(cyc);
                @(posedge clk); #1;
                n++;
            end
            s_eth_hdr_valid = 1'b0;
            if (!ok) begin
                vectors++; miscompares++;
                $display("FAIL hdr_wait: got no hdr_ready expected within %0d cycles", WAIT_MAX);
                hq_d.delete(); hq_s.delete(); hq_t.delete(); hq_dly.delete();
            end
        end
    endtask

    task automatic drv_pay();
        int dly; int n; bit ok; logic [9:0] b;
        while (pq.size() > 0) begin
            dly = pq_dly.pop_front();
            b   = pq.pop_front();
            repeat (dly) begin @(posedge clk); #1; end
            {p_tuser, p_tlast, p_tdata} = b;
            p_tvalid = 1'b1;
            ok = 1'b0; n = 0;
            while (!ok && n < WAIT_MAX) begin
                @(negedge clk);
                ok = p_tready;
                if (ok) pacc_q.push_back(cyc);
                @(posedge clk); #1;
                n++;
            end
            p_tvalid = 1'b0;
            if (!ok) begin
                vectors++; miscompares++;
                $display("FAIL pay_wait: got no tready expected within %0d cycles", WAIT_MAX);
                pq.delete(); pq_dly.delete();
            end
        end
    endtask

    task automatic wait_drain();
        int n = 0;
        while (exp_q.size() > 0 && n < 3000) begin @(negedge clk); n++; end
        chk("drain", exp_q.size(), 32'd0);
        @(posedge clk); #1;
    endtask

    task automatic run_traffic();
        fork
            drv_hdr();
            drv_pay();
        join
        wait_drain();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] t1_lit [17];
        int len;
        t1_lit = '{8'h02, 8'h00, 8'h00, 8'h00, 8'h00, 8'h01,
                   8'h02, 8'h00, 8'h00, 8'h00, 8'h00, 8'h02,
                   8'h08, 8'h00, 8'h11, 8'h22, 8'h33};
        rst = 1'b1; s_eth_hdr_valid = 1'b0; s_eth_dest_mac = 48'h0; s_eth_src_mac = 48'h0;
        s_eth_type = 16'h0; p_tdata = 8'h00; p_tvalid = 1'b0; p_tlast = 1'b0; p_tuser = '0;
        repeat (3) @(posedge clk); #1;
        @(negedge clk);
        chk("rst_tvalid", m_tvalid, 32'd0);
        chk("rst_tlast", m_tlast, 32'd0);
        chk("rst_tdata", m_tdata, 32'd0);
        chk("rst_tuser", m_tuser, 32'd0);
        chk("rst_pay_tready", p_tready, 32'd0);
        chk("rst_busy", busy, 32'd0);
        chk("rst_hdr_ready", s_eth_hdr_ready, 32'd1);
        @(posedge clk); #1; rst = 1'b0;
        repeat (3) begin @(posedge clk); #1; end

        // T1: reference frame, ready held high
        clr(); tr_mode = 0;
        add_hdr(48'h020000000001, 48'h020000000002, 16'h0800, 0);
        add_pay(8'h11, 1'b0, 1'b0, 0); add_pay(8'h22, 1'b0, 1'b0, 0); add_pay(8'h33, 1'b1, 1'b0, 0);
        run_traffic();
        chk("t1_len", cap_q.size(), 32'd17);
        if (cap_q.size() == 17) begin
            for (int i = 0; i < 17; i++) chk("t1_lit", cap_q[i], {1'b0, (i == 16), t1_lit[i]});
            chk("t1_contig", cap_cyc_q[16] - cap_cyc_q[0], 32'd16);
            chk("t1_latency", cap_cyc_q[0] - hs_q[0], 32'd2);
        end

        // T2: same frame under toggling ready
        clr(); tr_mode = 1;
        add_hdr(48'h020000000001, 48'h020000000002, 16'h0800, 0);
        add_pay(8'h11, 1'b0, 1'b0, 0); add_pay(8'h22, 1'b0, 1'b0, 0); add_pay(8'h33, 1'b1, 1'b0, 0);
        run_traffic();
        chk("t2_len", cap_q.size(), 32'd17);
        if (cap_q.size() == 17) begin
            for (int i = 0; i < 17; i++) chk("t2_lit", cap_q[i], {1'b0, (i == 16), t1_lit[i]});
        end

        // T3: back-to-back frames with headers pre-presented
        clr(); tr_mode = 0;
        add_hdr(48'h111111111111, 48'h222222222222, 16'h86DD, 0);
        add_pay(8'h5A, 1'b1, 1'b0, 0);
        add_hdr(48'h333333333333, 48'h444444444444, 16'h0806, 0);
        add_pay(8'hC3, 1'b0, 1'b0, 0); add_pay(8'h3C, 1'b1, 1'b0, 0);
        run_traffic();
        chk("t3_len", cap_q.size(), 32'd31);
        if (cap_q.size() == 31 && hs_q.size() == 2) begin
            chk("t3_f1_contig", cap_cyc_q[14] - cap_cyc_q[0], 32'd14);
            chk("t3_gap", cap_cyc_q[15] - cap_cyc_q[14], 32'd2);
            chk("t3_f2_contig", cap_cyc_q[30] - cap_cyc_q[15], 32'd15);
            chk("t3_hdr2_after_tlast", hs_q[1], cap_cyc_q[14]);
        end

        // T4: payload presented 10 cycles before its header
        clr(); tr_mode = 0;
        add_hdr(48'hDEADBEEF0001, 48'hCAFEF00D0002, 16'h88B5, 10);
        add_pay(8'hAA, 1'b1, 1'b1, 0);
        run_traffic();
        chk("t4_len", cap_q.size(), 32'd15);
        if (cap_q.size() == 15 && pacc_q.size() == 1 && hs_q.size() == 1) begin
            chk("t4_accept_time", pacc_q[0] - hs_q[0], 32'd15);
            chk("t4_last", cap_q[14], 32'h3AA);
        end

        // T5: reset after a few header bytes have gone out
        clr(); tr_mode = 0;
        add_hdr(48'h0A0B0C0D0E0F, 48'h101112131415, 16'h0800, 0);
        drv_hdr();
        begin
            int n = 0;
            while (cap_q.size() < 5 && n < 100) begin @(negedge clk); n++; end
            chk("t5_five_out", cap_q.size() >= 5, 32'd1);
        end
        @(posedge clk); #1; rst = 1'b1;
        @(posedge clk); #1; rst = 1'b0;
        exp_q.delete();
        @(negedge clk);
        chk("t5_tvalid", m_tvalid, 32'd0);
        chk("t5_busy", busy, 32'd0);
        chk("t5_tlast", m_tlast, 32'd0);
        @(posedge clk); #1;
        clr();
        add_hdr(48'hA1B2C3D4E5F6, 48'h665544332211, 16'h0800, 0);
        add_pay(8'h01, 1'b0, 1'b0, 0); add_pay(8'h02, 1'b1, 1'b0, 0);
        run_traffic();
        chk("t5_new_len", cap_q.size(), 32'd16);
        if (cap_q.size() == 16) chk("t5_first", cap_q[0], 32'h0A1);

        // T6: single-byte payload with a 4-cycle input gap
        clr(); tr_mode = 0;
        add_hdr(48'h0000000000FF, 48'hFF0000000000, 16'h0800, 0);
        add_pay(8'h00, 1'b1, 1'b0, 19);
        run_traffic();
        chk("t6_len", cap_q.size(), 32'd15);
        if (cap_q.size() == 15 && pacc_q.size() == 1) begin
            chk("t6_stall", cap_cyc_q[14] - cap_cyc_q[13], 32'd5);
            chk("t6_last", cap_q[14], 32'h100);
            chk("t6_busy_at_acc", busy_log[pacc_q[0]], 32'd1);
            chk("t6_busy_after", busy_log[pacc_q[0] + 1], 32'd0);
        end

        // Randomized frames under all ready patterns
        for (int blk = 0; blk < 3; blk++) begin
            tr_mode = blk;
            for (int f = 0; f < 10; f++) begin
                add_hdr({$urandom, $urandom_range(0, 65535)}, {$urandom, $urandom_range(0, 65535)},
                        16'($urandom), $urandom_range(0, 3));
                len = $urandom_range(1, 16);
                for (int b = 0; b < len; b++)
                    add_pay(8'($urandom), (b == len - 1), 1'($urandom_range(0, 1)), $urandom_range(0, 2));
            end
            clr();
            run_traffic();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
